// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP32 field widths, class encoding and flag indices
package fpu_pkg;

  localparam int FP_W   = 32;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  localparam int FLAG_W  = 3;
  localparam int FLAG_NV = 2;
  localparam int FLAG_OF = 1;
  localparam int FLAG_UF = 0;

  typedef enum logic [2:0] {
    ZERO    = 3'd0,
    SUBNORM = 3'd1,
    NORMAL  = 3'd2,
    INF     = 3'd3,
    QNAN    = 3'd4,
    SNAN    = 3'd5
  } fp_class_t;

  function automatic logic is_finite(input fp_class_t c);
    return (c == ZERO) || (c == SUBNORM) || (c == NORMAL);
  endfunction

  function automatic logic is_nonzero_finite(input fp_class_t c);
    return (c == SUBNORM) || (c == NORMAL);
  endfunction

endpackage

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - combinational FP32 operand/result classifier
module fp_classify
  import fpu_pkg::*;
(
  input  logic [FP_W-1:0] value,
  output fp_class_t       cls
);

  logic [EXP_W-1:0]  exp_f;
  logic [FRAC_W-1:0] frac_f;

  assign exp_f  = value[FP_W-2 -: EXP_W];
  assign frac_f = value[FRAC_W-1:0];

  always_comb begin
    cls = NORMAL;
    if (exp_f == '0) begin
      cls = (frac_f == '0) ? ZERO : SUBNORM;
    end else if (exp_f == EXP_MAX) begin
      if (frac_f == '0)             cls = INF;
      else if (frac_f[FRAC_W-1])    cls = QNAN;
      else                          cls = SNAN;
    end
  end

endmodule

// File: rtl/fp_mult_result_stage.sv
// rtl/fp_mult_result_stage.sv - multiplier result buffer with classification and sticky flags
module fp_mult_result_stage
  import fpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP_W-1:0]   in_data1,
  input  logic [FP_W-1:0]   in_data2,
  input  logic [FP_W-1:0]   in_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP_W-1:0]   out_result,
  output logic [2:0]        out_class,
  input  logic              flag_clr,
  output logic [FLAG_W-1:0] flags
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fp_class_t cls_a, cls_b, cls_r;

  fp_classify u_cls_a (.value(in_data1),  .cls(cls_a));
  fp_classify u_cls_b (.value(in_data2),  .cls(cls_b));
  fp_classify u_cls_r (.value(in_result), .cls(cls_r));

  logic [FP_W-1:0] result_mem [DEPTH];
  fp_class_t       class_mem  [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic push, pop;
  logic [FLAG_W-1:0] new_flags;

  // DEPTH is a power of two, so pointers wrap by natural overflow
  assign in_ready   = (count != CNT_W'(DEPTH)) && !rst;
  assign out_valid  = (count != '0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign out_result = result_mem[rd_ptr];
  assign out_class  = class_mem[rd_ptr];

  always_comb begin
    new_flags = '0;
    new_flags[FLAG_NV] = (cls_a == SNAN) || (cls_b == SNAN) ||
                         ((cls_a == INF) && (cls_b == ZERO)) ||
                         ((cls_a == ZERO) && (cls_b == INF));
    new_flags[FLAG_OF] = (cls_r == INF) && is_finite(cls_a) && is_finite(cls_b);
    new_flags[FLAG_UF] = ((cls_r == ZERO) || (cls_r == SUBNORM)) &&
                         is_nonzero_finite(cls_a) && is_nonzero_finite(cls_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        result_mem[i] <= '0;
        class_mem[i]  <= ZERO;
      end
    end else begin
      if (push) begin
        result_mem[wr_ptr] <= in_result;
        class_mem[wr_ptr]  <= cls_r;
        wr_ptr             <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // a clear and a flag-setting push in the same cycle leave the new flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= '0;
    end else if (flag_clr || push) begin
      flags <= (flag_clr ? '0 : flags) | (push ? new_flags : '0);
    end
  end

endmodule

// File: tb/tb_fp_mult_result_stage.sv
// tb/tb_fp_mult_result_stage.sv - scoreboard bench for fp_mult_result_stage
module tb_fp_mult_result_stage;
  import fpu_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data1, in_data2, in_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_class;
  logic        flag_clr;
  logic [2:0]  flags;

  fp_mult_result_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data1(in_data1), .in_data2(in_data2), .in_result(in_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_class(out_class),
    .flag_clr(flag_clr), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] result;
    logic [2:0]  cls;
  } exp_t;

  exp_t        sb_q[$];
  logic [2:0]  model_flags = 3'b000;
  int          occ_before  = 0;
  bit          fresh       = 1'b1;
  int          n_vec       = 0;
  int          n_fail      = 0;

  function automatic logic [2:0] ref_class(input logic [31:0] x);
    int unsigned e = x[30:23];
    int unsigned f = x[22:0];
    if (e == 0)   return (f == 0) ? 3'd0 : 3'd1;
    if (e == 255) begin
      if (f == 0)            return 3'd3;
      if (f >= 32'h400000)   return 3'd4;
      return 3'd5;
    end
    return 3'd2;
  endfunction

  // {NV, OF, UF} from the operand/result categories
  function automatic logic [2:0] ref_flags(input logic [31:0] a, b, r);
    logic [2:0] ca = ref_class(a), cb = ref_class(b), cr = ref_class(r);
    bit a_fin = (ca <= 3'd2), b_fin = (cb <= 3'd2);
    bit nv = (ca == 3'd5) || (cb == 3'd5) || (ca == 3'd3 && cb == 3'd0) || (ca == 3'd0 && cb == 3'd3);
    bit of = (cr == 3'd3) && a_fin && b_fin;
    bit uf = (cr <= 3'd1) && a_fin && b_fin && ca != 3'd0 && cb != 3'd0;
    return {nv, of, uf};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // monitor: compares live outputs against the model and retires popped entries
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(sb_q.size() < DEPTH && !rst));
      chk("flags", 32'(flags), 32'(model_flags));
      if (sb_q.size() != 0) begin
        chk("out_result", out_result, sb_q[0].result);
        chk("out_class", 32'(out_class), 32'(sb_q[0].cls));
      end else if (fresh) begin
        chk("empty_result", out_result, 32'h0);
        chk("empty_class", 32'(out_class), 32'(ZERO));
      end
      occ_before = sb_q.size();
      if (!rst && out_ready && sb_q.size() != 0) void'(sb_q.pop_front());
    end
  end

  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] r, input logic ordy, input logic clr,
                      input logic rs);
    @(posedge clk);
    #1;
    in_valid = v; in_data1 = a; in_data2 = b; in_result = r;
    out_ready = ordy; flag_clr = clr; rst = rs;
    @(negedge clk);
    #1;
    if (rs) begin
      sb_q.delete();
      model_flags = 3'b000;
      fresh = 1'b1;
    end else begin
      if (clr) model_flags = 3'b000;
      if (v && occ_before < DEPTH) begin
        sb_q.push_back('{result: r, cls: ref_class(r)});
        model_flags = model_flags | ref_flags(a, b, r);
        fresh = 1'b0;
      end
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'h0, 32'h0, 32'h0, ordy, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_fp();
    logic s = 1'($urandom);
    case ($urandom_range(0, 9))
      0: return {s, 31'h0};
      1: return {s, 8'h00, 23'($urandom) | 23'h1};
      2: return {s, 8'hFF, 23'h0};
      3: return {s, 8'hFF, 1'b1, 22'($urandom)};
      4: return {s, 8'hFF, 1'b0, 22'($urandom) | 22'h1};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data1 = '0; in_data2 = '0; in_result = '0;
    out_ready = 1'b0; flag_clr = 1'b0;
    step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);

    step(1'b1, 32'h42C86666, 32'h42B50000, 32'h460DB066, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    step(1'b1, 32'h40ACCCCD, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    step(1'b1, 32'h40ACCCCD, 32'h7F800001, 32'h7FC00001, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h7F800000, 32'h00000000, 32'h7FC00000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    step(1'b1, 32'h7F000000, 32'h40000000, 32'h7F800000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h00800000, 32'h3F000000, 32'h00400000, 1'b1, 1'b1, 1'b0);
    step(1'b1, 32'h00800000, 32'h3F000000, 32'h00400000, 1'b1, 1'b1, 1'b0);
    step(1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 3; i++)
      step(1'b1, 32'h3F800000, 32'h40000000 + 32'(i), 32'h40000000 + 32'(i), 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    step(1'b1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h7F000000, 32'h40000000, 32'h7F800000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h40400000, 32'h40000000, 32'h40C00000, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a = rand_fp();
      logic [31:0] b = rand_fp();
      logic [31:0] r = rand_fp();
      step(1'($urandom_range(0, 9) < 7), a, b, r, 1'($urandom_range(0, 9) < 6),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 49) == 0));
    end
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
